antirrebote_botones: RTL
========================

# antirrebote_botones

Conditions the two raw DPWM frequency-selection push-buttons (increase/decrease) and drives the 3-bit programmable frequency counter directly. Each button is synchronised, debounced by a per-button state machine and converted into a clean single-clock-cycle pulse on the accepted press. The up/down counter consumes these pulses in place of the raw buttons, so each physical press moves the frequency index by exactly one step.

## Interface
- `N_DEBOUNCE`, default 500000: consecutive stable clock cycles required to accept a level change (10 ms at 50 MHz). Legal range is 2 to 2^CNT_W − 1.
- `CNT_W`, default 20: width of each debounce counter.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `boton_aumento_in`  input  1  raw, asynchronous, bouncing "increase" button (high = pressed).
- `boton_disminuye_in`  input  1  raw, asynchronous, bouncing "decrease" button (high = pressed).
- `enable`  input  1  pulse-output gate; filtering continues while it is low.
- `pulso_aumento`  output  1  one-cycle pulse on an accepted increase press; feeds the counter's `boton_aumento`.
- `pulso_disminuye`  output  1  one-cycle pulse on an accepted decrease press; feeds the counter's `boton_disminuye`.
- `aumento_estable`  output  1  debounced level of the increase button.
- `disminuye_estable`  output  1  debounced level of the decrease button.
- `conflicto`  output  1  one-cycle flag: both presses were accepted in the same cycle.

## Operation
- **Synchroniser:** each raw input passes through a two-flop chain (`s1`, `s2`). The filter sees only `s2`.
- **Per-button FSM:** four states.
  - REPOSO (stable 0): `s2`=1 → FILTRO_PRESION, counter = 0.
  - FILTRO_PRESION: on `s2`=0 → REPOSO, counter = 0. On `s2`=1 with counter = N_DEBOUNCE−1 → PRESIONADO. Otherwise increment the counter.
  - PRESIONADO (stable 1): `s2`=0 → FILTRO_LIBERA, counter = 0.
  - FILTRO_LIBERA: on `s2`=1 → PRESIONADO, counter = 0. On `s2`=0 with counter = N_DEBOUNCE−1 → REPOSO. Otherwise increment the counter.
- **Stable level:** `*_estable` is 1 exactly in PRESIONADO and FILTRO_LIBERA.
- **Press pulse:** a press is accepted on the FILTRO_PRESION→PRESIONADO transition. The corresponding `pulso_*` is registered high for exactly one cycle, only if `enable`=1 in the acceptance cycle.
- **Release:** an accepted release (→REPOSO) never produces a pulse.
- **Glitch rejection:** a glitch or bounce shorter than N_DEBOUNCE cycles returns the FSM to its origin state with no pulse and no change in stable level.
- **Simultaneous acceptance:** if both FSMs accept a press in the same cycle, both pulses are suppressed and `conflicto` = 1 for that cycle.
- **Non-simultaneous presses:** presses accepted in different cycles, including while the other button is held, each pulse normally.
- **`enable` low:** FSMs and stable levels keep tracking. A press accepted while `enable`=0 is lost; it is not replayed when `enable` rises.
- **Counter overflow:** the counter never exceeds N_DEBOUNCE−1, so no wrap-around is possible.

## Timing
- **Reset:** on a clock edge with `reset`=1, these all go to 0: sync flops, FSMs (REPOSO), counters, `pulso_aumento`, `pulso_disminuye`, `aumento_estable`, `disminuye_estable` and `conflicto`. Reset overrides every other input.
- **Press latency:** raw input goes high and stays high before edge 1. `s2` is high after edge 2. FILTRO_PRESION is entered at edge 3. Acceptance, the pulse and `*_estable` all go high after edge 3+N_DEBOUNCE. The pulse is low again after the next edge.
- **Release latency:** the same count applies; `*_estable` falls after edge 3+N_DEBOUNCE counted from the release.
- **Reset mid-operation:** filtering progress is discarded. A button held through reset is re-filtered from REPOSO after reset deasserts and pulses after the full latency.
- **Pulse spacing:** pulses from one button are separated by at least 2·N_DEBOUNCE+2 cycles, because a full release must be accepted between presses.

## Test plan
All scenarios use N_DEBOUNCE = 8.
- **Clean press:** hold `boton_aumento_in` high from cycle 0 → `pulso_aumento` high only in cycle 11; `aumento_estable` = 1 from cycle 11; `pulso_disminuye` stays 0.
- **Bouncing press:** toggle the input with high times of 3, 5 and 2 cycles, then hold high → exactly one pulse, 11 cycles after the final rising edge.
- **Glitch and release:**
  - 7-cycle high glitch → no pulse, `aumento_estable` stays 0.
  - Release after an accepted press → no pulse; `aumento_estable` falls 11 cycles after the release.
- **Simultaneous press:** both inputs rise in the same cycle → `conflicto` = 1 in cycle 11 and both pulses stay 0. With `boton_disminuye_in` then rising 4 cycles after `boton_aumento_in` → two separate pulses in cycles 11 and 15.
- **Enable low:** hold `enable` = 0 across acceptance → no pulse, but `aumento_estable` = 1. Raising `enable` afterwards produces no pulse.
- **Reset mid-filter:** assert `reset` for one cycle at cycle 6 of a held press → all outputs 0 after that edge; the pulse then appears 11 cycles after `reset` deasserts.

Source files
------------

// File: rtl/antirrebote_botones_if.sv
// Signal bundle between the raw frequency-selection buttons and the debouncer.
// The debouncer side is the slave; whatever drives the buttons is the master.
interface antirrebote_botones_if;
    logic boton_aumento_in;
    logic boton_disminuye_in;
    logic enable;
    logic pulso_aumento;
    logic pulso_disminuye;
    logic aumento_estable;
    logic disminuye_estable;
    logic conflicto;

    modport master (
        output boton_aumento_in,
        output boton_disminuye_in,
        output enable,
        input  pulso_aumento,
        input  pulso_disminuye,
        input  aumento_estable,
        input  disminuye_estable,
        input  conflicto
    );

    modport slave (
        input  boton_aumento_in,
        input  boton_disminuye_in,
        input  enable,
        output pulso_aumento,
        output pulso_disminuye,
        output aumento_estable,
        output disminuye_estable,
        output conflicto
    );
endinterface

// File: rtl/antirrebote_botones.sv
// Synchronises and debounces the increase/decrease buttons and turns each
// accepted press into a single-cycle pulse for the frequency counter.
module antirrebote_botones #(
    parameter int N_DEBOUNCE = 500000,
    parameter int CNT_W      = 20
) (
    input logic                  clk,
    input logic                  reset,
    antirrebote_botones_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO,
        FILTRO_PRESION,
        PRESIONADO,
        FILTRO_LIBERA
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_DEBOUNCE - 1);

    // Index 0 is the increase button, index 1 the decrease button.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    estado_t          estado      [2];
    estado_t          estado_next [2];
    logic [CNT_W-1:0] cnt         [2];
    logic [CNT_W-1:0] cnt_next    [2];
    logic [1:0]       acepta;
    logic             pulso_aumento_q;
    logic             pulso_disminuye_q;
    logic             conflicto_q;

    assign raw = {bus.boton_disminuye_in, bus.boton_aumento_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                estado[i] <= REPOSO;
                cnt[i]    <= '0;
            end else begin
                estado[i] <= estado_next[i];
                cnt[i]    <= cnt_next[i];
            end
        end
    end

    // Counter saturates at CNT_MAX because reaching it always leaves the filter state.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            estado_next[i] = estado[i];
            cnt_next[i]    = cnt[i];
            acepta[i]      = 1'b0;
            case (estado[i])
                REPOSO: begin
                    if (s2[i]) begin
                        estado_next[i] = FILTRO_PRESION;
                        cnt_next[i]    = '0;
                    end
                end
                FILTRO_PRESION: begin
                    if (!s2[i]) begin
                        estado_next[i] = REPOSO;
                        cnt_next[i]    = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        estado_next[i] = PRESIONADO;
                        acepta[i]      = 1'b1;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_W'(1);
                    end
                end
                PRESIONADO: begin
                    if (!s2[i]) begin
                        estado_next[i] = FILTRO_LIBERA;
                        cnt_next[i]    = '0;
                    end
                end
                FILTRO_LIBERA: begin
                    if (s2[i]) begin
                        estado_next[i] = PRESIONADO;
                        cnt_next[i]    = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        estado_next[i] = REPOSO;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    estado_next[i] = REPOSO;
                    cnt_next[i]    = '0;
                end
            endcase
        end
    end

    // Simultaneous acceptance is ambiguous for the counter, so both pulses are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            pulso_aumento_q   <= 1'b0;
            pulso_disminuye_q <= 1'b0;
            conflicto_q       <= 1'b0;
        end else begin
            pulso_aumento_q   <= acepta[0] & ~acepta[1] & bus.enable;
            pulso_disminuye_q <= acepta[1] & ~acepta[0] & bus.enable;
            conflicto_q       <= acepta[0] & acepta[1];
        end
    end

    assign bus.pulso_aumento     = pulso_aumento_q;
    assign bus.pulso_disminuye   = pulso_disminuye_q;
    assign bus.conflicto         = conflicto_q;
    assign bus.aumento_estable   = (estado[0] == PRESIONADO) || (estado[0] == FILTRO_LIBERA);
    assign bus.disminuye_estable = (estado[1] == PRESIONADO) || (estado[1] == FILTRO_LIBERA);

endmodule
